updown_counter: RTL and testbench
=================================

UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
- REQ-001 SHALL have parameter WIDTH, default 8, giving the count, load-value and limit width in bits.
- REQ-002 SHALL have parameter PSC_W, default 4, giving the prescaler width in bits; used only under COUNTER_PRESCALE_EN.
- REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
- REQ-005 SHALL have port en  input  1  count enable; a step is attempted only while high.
- REQ-006 SHALL have port ld  input  1  load count from v.
- REQ-007 SHALL have port v  input  WIDTH  preload value.
- REQ-008 SHALL have port dir  input  1  1 = count up, 0 = count down.
- REQ-009 SHALL have port mode  input  2  00 wrap, 01 saturate, 10 one-shot; 11 behaves as 00.
- REQ-010 SHALL have port limit  input  WIDTH  terminal value for up-counting and reload value for down-wrap.
- REQ-011 SHALL have port psc  input  PSC_W  prescale divisor minus 1; present only under COUNTER_PRESCALE_EN.
- REQ-012 SHALL have port count  output  WIDTH  current count, registered.
- REQ-013 SHALL have port tc  output  1  terminal-count pulse, registered, one cycle wide.
- REQ-014 SHALL have port sat  output  1  saturate mode active with count at terminal, registered.
- REQ-015 SHALL have port halted  output  1  one-shot completed, registered.

Function
- REQ-016 SHALL apply priority per edge: rst, then ld, then qualified step.
- REQ-017 SHALL define a qualified step as en=1, tick=1 and halted=0; tick is 1 every cycle without the macro.
- REQ-018 SHALL define terminal as count>=limit when dir=1 and count==0 when dir=0; unsigned compare.
- REQ-019 SHALL, on a qualified step at non-terminal count, change count by +1 (dir=1) or -1 (dir=0), modulo 2^WIDTH.
- REQ-020 SHALL, in wrap mode, set count to 0 (up) or to limit (down) on a qualified step at terminal, and pulse tc.
- REQ-021 SHALL, in saturate mode, hold count on a qualified step at terminal, and pulse tc only when sat goes 0->1.
- REQ-022 SHALL drive sat=1 when mode=01 and count is at terminal for the current dir, updated each edge; reversing dir releases it.
- REQ-023 SHALL implement one-shot as FSM RUN/HALT: in RUN it behaves as wrap; a terminal step wraps count, pulses tc, enters HALT.
- REQ-024 SHALL, in HALT, hold count with halted=1, ignore en and mode changes, and return to RUN only on ld or rst.
- REQ-025 SHALL, on ld, set count=v, clear halted, sat and the prescaler, and drive tc=0 on the next cycle, whatever v is relative to limit.
- REQ-026 SHALL register tc high for exactly one cycle after the edge of the causing step, and low otherwise.
- REQ-027 SHALL sample mode, dir and limit at every edge; a change applies from that edge with no pipeline delay.
- REQ-028 SHALL give count/tc a latency of one edge from the qualifying inputs.

Reset
- REQ-029 SHALL, on rst=1 at an edge, set count=0, tc=0, sat=0, halted=0, FSM=RUN and prescaler=0, overriding ld and en.
- REQ-030 SHALL take rst mid-operation, including in HALT, with the same result and no residual tc pulse.

Configuration
- REQ-031 SHALL, with COUNTER_PRESCALE_EN defined, add psc and an internal PSC_W-bit divider that advances on en=1 cycles, giving tick=1 and clearing when divider==psc.
- REQ-032 SHALL, without COUNTER_PRESCALE_EN, omit the psc port and the divider, with tick=1 every cycle.

Verification
- REQ-033 SHALL cover wrap-up: WIDTH=8, mode=00, dir=1, limit=9, en=1 from reset -> count 0..9,0,1; tc high only in the cycle after 9->0.
- REQ-034 SHALL cover wrap-down: ld v=2, then dir=0, limit=5, en=1 -> count 2,1,0,5,4; tc one pulse after 0->5.
- REQ-035 SHALL cover saturate: mode=01, limit=3, up from 0 -> 0,1,2,3,3,3; tc once; sat=1; then dir=0 -> count 2, sat=0.
- REQ-036 SHALL cover one-shot: mode=10, limit=4, up from 0 -> 0..4,0 then halted=1, count stays 0 with en=1; ld v=1 -> halted=0, count 1,2.
- REQ-037 SHALL cover reset priority: count=0x37, rst=1 with ld=1, v=0xAA, en=1 -> count=0x00, tc=0, halted=0 next cycle.
- REQ-038 SHALL cover the prescaler (macro defined): psc=2, en=1, limit=0xFF -> count advances once every 3 cycles; ld clears the divider.

Source files
------------

// File: rtl/updown_counter.sv
// Up/down counter with wrap, saturate and one-shot modes; count/tc/sat/halted registered, one edge latency.
// Optional prescaler under `COUNTER_PRESCALE_EN` adds the psc port; no backpressure.
module updown_counter #(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] v,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PSC_W-1:0] psc,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             sat,
  output logic             halted
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  if (PSC_W < 1) begin : g_psc_chk
    $error("PSC_W must be at least 1");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_sat;
  logic             r_halted;

  logic             w_tick;
  logic             w_term;
  logic             w_step;
  logic             w_is_sat;
  logic             w_is_os;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_wrap_val;

`ifdef COUNTER_PRESCALE_EN
  logic [PSC_W-1:0] r_div;
  assign w_tick = (r_div == psc);
`else
  assign w_tick = 1'b1;
`endif

  assign w_term     = dir ? (r_count >= limit) : (r_count == '0);
  assign w_step     = en & w_tick & (r_state == ST_RUN);
  assign w_is_sat   = (mode == 2'b01);
  assign w_is_os    = (mode == 2'b10);
  assign w_next     = dir ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
  assign w_wrap_val = dir ? '0 : limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_count  <= '0;
      r_tc     <= 1'b0;
      r_sat    <= 1'b0;
      r_halted <= 1'b0;
`ifdef COUNTER_PRESCALE_EN
      r_div    <= '0;
`endif
    end else if (ld) begin
      r_state  <= ST_RUN;
      r_count  <= v;
      r_tc     <= 1'b0;
      r_sat    <= 1'b0;
      r_halted <= 1'b0;
`ifdef COUNTER_PRESCALE_EN
      r_div    <= '0;
`endif
    end else begin
      r_tc <= 1'b0;
`ifdef COUNTER_PRESCALE_EN
      if (en) begin
        r_div <= w_tick ? '0 : (r_div + PSC_W'(1));
      end
`endif
      if (r_state == ST_HALT) begin
        // Frozen until ld/rst: mode and en are deliberately ignored here.
        r_sat    <= 1'b0;
        r_halted <= 1'b1;
      end else begin
        r_sat <= w_is_sat & w_term;
        if (w_step) begin
          if (!w_term) begin
            r_count <= w_next;
          end else if (w_is_sat) begin
            r_tc <= ~r_sat;
          end else begin
            r_count <= w_wrap_val;
            r_tc    <= 1'b1;
            if (w_is_os) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign count  = r_count;
  assign tc     = r_tc;
  assign sat    = r_sat;
  assign halted = r_halted;

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter: vector table through a scoreboard queue, plus prescaler sequence.
module tb_updown_counter;

  typedef struct {
    logic       rst;
    logic       en;
    logic       ld;
    logic [7:0] v;
    logic       dir;
    logic [1:0] mode;
    logic [7:0] limit;
    logic [7:0] e_cnt;
    logic       e_tc;
    logic       e_sat;
    logic       e_halt;
  } vec_t;

  typedef struct {
    logic [7:0] cnt;
    logic       tc;
    logic       sat;
    logic       halt;
    int         id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       ld = 1'b0;
  logic [7:0] v = 8'h00;
  logic       dir = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [7:0] limit = 8'h00;
`ifdef COUNTER_PRESCALE_EN
  logic [3:0] psc = 4'd0;
`endif
  logic [7:0] count;
  logic       tc;
  logic       sat;
  logic       halted;

  int n_checks = 0;
  int n_fail = 0;

  vec_t vecs[$];
  exp_t sb[$];

  updown_counter #(.WIDTH(8), .PSC_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .ld     (ld),
    .v      (v),
    .dir    (dir),
    .mode   (mode),
    .limit  (limit),
`ifdef COUNTER_PRESCALE_EN
    .psc    (psc),
`endif
    .count  (count),
    .tc     (tc),
    .sat    (sat),
    .halted (halted)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic e, input logic l, input logic [7:0] vv,
                              input logic d, input logic [1:0] m, input logic [7:0] lim,
                              input logic [7:0] ec, input logic et, input logic es, input logic eh);
    vec_t x;
    x.rst = r; x.en = e; x.ld = l; x.v = vv; x.dir = d; x.mode = m; x.limit = lim;
    x.e_cnt = ec; x.e_tc = et; x.e_sat = es; x.e_halt = eh;
    vecs.push_back(x);
  endfunction

  task automatic apply(input vec_t x, input int id);
    exp_t e;
    exp_t got;
    rst = x.rst; en = x.en; ld = x.ld; v = x.v; dir = x.dir; mode = x.mode; limit = x.limit;
    e.cnt = x.e_cnt; e.tc = x.e_tc; e.sat = x.e_sat; e.halt = x.e_halt; e.id = id;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL step%0d: scoreboard empty", id);
    end else begin
      got = sb.pop_front();
      if ({count, tc, sat, halted} !== {got.cnt, got.tc, got.sat, got.halt}) begin
        n_fail++;
        $display("FAIL step%0d: got count=%0h tc=%0b sat=%0b halted=%0b, want count=%0h tc=%0b sat=%0b halted=%0b",
                 got.id, count, tc, sat, halted, got.cnt, got.tc, got.sat, got.halt);
      end
    end
  endtask

  initial begin
    // reset state, then wrap-up 0..9,0,1 with a single tc after 9->0
    add(1, 0, 0, 8'h00, 1, 2'b00, 8'd9, 8'd0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 1, 0, 8'h00, 1, 2'b00, 8'd9, 8'(k), 0, 0, 0);
    add(0, 1, 0, 8'h00, 1, 2'b00, 8'd9, 8'd0, 1, 0, 0);
    add(0, 1, 0, 8'h00, 1, 2'b00, 8'd9, 8'd1, 0, 0, 0);
    add(0, 0, 0, 8'h00, 1, 2'b00, 8'd9, 8'd1, 0, 0, 0);
    // wrap-down 2,1,0,5,4
    add(0, 1, 1, 8'd2,  0, 2'b00, 8'd5, 8'd2, 0, 0, 0);
    add(0, 1, 0, 8'h00, 0, 2'b00, 8'd5, 8'd1, 0, 0, 0);
    add(0, 1, 0, 8'h00, 0, 2'b00, 8'd5, 8'd0, 0, 0, 0);
    add(0, 1, 0, 8'h00, 0, 2'b00, 8'd5, 8'd5, 1, 0, 0);
    add(0, 1, 0, 8'h00, 0, 2'b00, 8'd5, 8'd4, 0, 0, 0);
    // saturate at 3, then reversing releases sat
    add(1, 0, 0, 8'h00, 1, 2'b01, 8'd3, 8'd0, 0, 0, 0);
    add(0, 1, 0, 8'h00, 1, 2'b01, 8'd3, 8'd1, 0, 0, 0);
    add(0, 1, 0, 8'h00, 1, 2'b01, 8'd3, 8'd2, 0, 0, 0);
    add(0, 1, 0, 8'h00, 1, 2'b01, 8'd3, 8'd3, 0, 0, 0);
    add(0, 1, 0, 8'h00, 1, 2'b01, 8'd3, 8'd3, 1, 1, 0);
    add(0, 1, 0, 8'h00, 1, 2'b01, 8'd3, 8'd3, 0, 1, 0);
    add(0, 1, 0, 8'h00, 0, 2'b01, 8'd3, 8'd2, 0, 0, 0);
    // one-shot to 4, halt ignores en and mode, ld restarts
    add(1, 0, 0, 8'h00, 1, 2'b10, 8'd4, 8'd0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) add(0, 1, 0, 8'h00, 1, 2'b10, 8'd4, 8'(k), 0, 0, 0);
    add(0, 1, 0, 8'h00, 1, 2'b10, 8'd4, 8'd0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 1, 2'b10, 8'd4, 8'd0, 0, 0, 1);
    add(0, 1, 0, 8'h00, 1, 2'b00, 8'd4, 8'd0, 0, 0, 1);
    add(0, 1, 1, 8'd1,  1, 2'b10, 8'd4, 8'd1, 0, 0, 0);
    add(0, 1, 0, 8'h00, 1, 2'b10, 8'd4, 8'd2, 0, 0, 0);
    // reset beats ld and en
    add(0, 0, 1, 8'h37, 1, 2'b00, 8'd9, 8'h37, 0, 0, 0);
    add(1, 1, 1, 8'hAA, 1, 2'b00, 8'd9, 8'h00, 0, 0, 0);
    // one-shot down from 0 halts at once; reset while halted
    add(0, 1, 0, 8'h00, 0, 2'b10, 8'd7, 8'd7, 1, 0, 1);
    add(1, 1, 0, 8'h00, 0, 2'b10, 8'd7, 8'd0, 0, 0, 0);
    // loaded above limit counts as terminal going up
    add(0, 0, 1, 8'd20, 1, 2'b00, 8'd9, 8'd20, 0, 0, 0);
    add(0, 1, 0, 8'h00, 1, 2'b00, 8'd9, 8'd0, 1, 0, 0);
    // mode 11 wraps like 00 at the top of the range
    add(0, 0, 1, 8'hFE, 1, 2'b11, 8'hFF, 8'hFE, 0, 0, 0);
    add(0, 1, 0, 8'h00, 1, 2'b11, 8'hFF, 8'hFF, 0, 0, 0);
    add(0, 1, 0, 8'h00, 1, 2'b11, 8'hFF, 8'h00, 1, 0, 0);
    // ld at a terminal count suppresses tc
    add(0, 1, 1, 8'd9,  1, 2'b00, 8'd9, 8'd9, 0, 0, 0);
    add(0, 1, 1, 8'd5,  1, 2'b00, 8'd9, 8'd5, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

`ifdef COUNTER_PRESCALE_EN
    begin
      vec_t p;
      psc = 4'd2;
      p.rst = 1; p.en = 0; p.ld = 0; p.v = 8'h00; p.dir = 1; p.mode = 2'b00; p.limit = 8'hFF;
      p.e_cnt = 8'd0; p.e_tc = 0; p.e_sat = 0; p.e_halt = 0;
      apply(p, 1000);
      p.rst = 0; p.en = 1;
      for (int k = 1; k <= 7; k++) begin
        p.e_cnt = 8'(k / 3);
        apply(p, 1000 + k);
      end
      // divider sits at 1 here; ld must restart it from 0
      p.ld = 1; p.v = 8'h10; p.e_cnt = 8'h10;
      apply(p, 1010);
      p.ld = 0;
      p.e_cnt = 8'h10; apply(p, 1011);
      p.e_cnt = 8'h10; apply(p, 1012);
      p.e_cnt = 8'h11; apply(p, 1013);
    end
`endif

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
